id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_fwd_mux.sv | 55 +++++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register stage.
// Optional feature macro: ID_EX_FWD_EN (operand forwarding from EX/MEM and MEM/WB).
package id_ex_stage_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CTRLW_DEFAULT = 8;
    localparam int REG_IDX_W     = 5;

    // Bit positions inside the opaque control bundle that this stage inspects
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Where an operand is sourced from
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_EXMEM = 2'd1,
        SRC_MEMWB = 2'd2,
        SRC_RF    = 2'd3
    } fwd_src_t;

    // True when a producer index names a real register that matches a consumer index
    function automatic logic idx_hit(input reg_idx_t producer, input reg_idx_t consumer);
        return (producer != '0) && (producer == consumer);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand source selection for the ID/EX stage.
// With ID_EX_FWD_EN defined, results still in EX/MEM or MEM/WB are bypassed
// (EX/MEM first, it is younger). Without it, the register file value is used and
// 'pending' flags that a writer in flight targets this operand, so the stage must stall.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  reg_idx_t          idx,
    input  logic [XLEN-1:0]   read_data,
    input  reg_idx_t          exmem_rd,
    input  logic              exmem_we,
    input  logic [XLEN-1:0]   exmem_result,
    input  reg_idx_t          memwb_rd,
    input  logic              memwb_we,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   data,
    output logic              pending
);

    fwd_src_t src;

    // Decide the operand source; x0 always reads as zero and is never bypassed
    always_comb begin
        src     = SRC_RF;
        pending = 1'b0;
        if (idx == '0) begin
            src = SRC_ZERO;
        end
`ifdef ID_EX_FWD_EN
        else if (exmem_we && (exmem_rd == idx)) begin
            src = SRC_EXMEM;
        end else if (memwb_we && (memwb_rd == idx)) begin
            src = SRC_MEMWB;
        end
`else
        else begin
            pending = (exmem_we && (exmem_rd == idx)) ||
                      (memwb_we && (memwb_rd == idx));
        end
`endif
    end

    // Steer the chosen source onto the operand bus
    always_comb begin
        case (src)
            SRC_ZERO:  data = '0;
            SRC_EXMEM: data = exmem_result;
            SRC_MEMWB: data = memwb_result;
            default:   data = read_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshakes, operand selection,
// hazard stall detection and a saturating stall-cycle counter.
// Optional feature macro: ID_EX_FWD_EN. When undefined, every RAW dependency on an
// in-flight writer (held instruction, EX/MEM, MEM/WB) stalls instead of bypassing.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CTRLW = CTRLW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      read_data1,
    input  logic [XLEN-1:0]      read_data2,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic [CTRLW-1:0]     ctrl,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_we,
    input  logic [XLEN-1:0]      exmem_result,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_we,
    input  logic [XLEN-1:0]      memwb_result,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [CTRLW-1:0]     out_ctrl,
    output logic                 stall,
    output logic [15:0]          stall_count
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            pend_a;
    logic            pend_b;
    logic            held_hit;
    logic            load_use;
    logic            held_raw;
    logic            hazard;
    logic            capture;
    logic            drain;

    fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .idx          (rs1),
        .read_data    (read_data1),
        .exmem_rd     (exmem_rd),
        .exmem_we     (exmem_we),
        .exmem_result (exmem_result),
        .memwb_rd     (memwb_rd),
        .memwb_we     (memwb_we),
        .memwb_result (memwb_result),
        .data         (op_a),
        .pending      (pend_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .idx          (rs2),
        .read_data    (read_data2),
        .exmem_rd     (exmem_rd),
        .exmem_we     (exmem_we),
        .exmem_result (exmem_result),
        .memwb_rd     (memwb_rd),
        .memwb_we     (memwb_we),
        .memwb_result (memwb_result),
        .data         (op_b),
        .pending      (pend_b)
    );

    // Hazard detection: the held instruction is the only producer whose result
    // cannot be bypassed in time when it is a load.
    always_comb begin
        held_hit = out_valid && (idx_hit(out_rd, rs1) || idx_hit(out_rd, rs2));
        load_use = held_hit && out_ctrl[CTRL_MEM_READ];
`ifdef ID_EX_FWD_EN
        held_raw = 1'b0;
`else
        held_raw = held_hit && out_ctrl[CTRL_REG_WRITE];
`endif
        hazard = in_valid && (load_use || held_raw || pend_a || pend_b);
    end

    assign stall    = hazard;
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign capture  = in_valid && in_ready && !flush;
    assign drain    = out_valid && out_ready;

    // Pipeline register: flush beats capture, capture beats draining to a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_a     <= op_a;
            out_b     <= op_b;
            out_imm   <= imm;
            out_pc    <= pc;
            out_rd    <= rd;
            out_ctrl  <= ctrl;
        end else if (drain) begin
            // Bubble: control is cleared so no side effects leak downstream
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end

    // Count stalled cycles, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic compared against a transaction-level reference of the stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] read_data1, read_data2, imm, pc;
    logic [7:0]  ctrl;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_result, memwb_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic [7:0]  out_ctrl;
    logic        stall;
    logic [15:0] stall_count;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: the instruction currently held by the stage
    logic        m_valid;
    logic [31:0] m_a, m_b, m_imm, m_pc;
    logic [4:0]  m_rd;
    logic [7:0]  m_ctrl;
    logic [15:0] m_cnt;

    id_ex_stage #(.XLEN(32), .CTRLW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .read_data1(read_data1), .read_data2(read_data2),
        .imm(imm), .pc(pc), .ctrl(ctrl),
        .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .stall(stall), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand value the stage should latch for source index idx
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_EX_FWD_EN
        if (exmem_we && exmem_rd == idx) return exmem_result;
        if (memwb_we && memwb_rd == idx) return memwb_result;
`endif
        return rf;
    endfunction

    function automatic logic reads(input logic [4:0] r);
        return (r != 5'd0) && (r == rs1 || r == rs2);
    endfunction

    function automatic logic ref_stall();
        logic h;
        h = m_valid && m_ctrl[1] && reads(m_rd);
`ifndef ID_EX_FWD_EN
        h = h || (m_valid && m_ctrl[0] && reads(m_rd)) ||
                 (exmem_we && reads(exmem_rd)) || (memwb_we && reads(memwb_rd));
`endif
        return in_valid && h;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_rd = 0; m_ctrl = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic h, rdy;
        h   = ref_stall();
        rdy = (!m_valid || out_ready) && !h;
        if (h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (flush) begin
            m_valid = 0; m_ctrl = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            m_a     = ref_operand(rs1, read_data1);
            m_b     = ref_operand(rs2, read_data2);
            m_imm   = imm; m_pc = pc; m_rd = rd; m_ctrl = ctrl;
        end else if (m_valid && out_ready) begin
            m_valid = 0; m_ctrl = 0;
        end
    endtask

    task automatic comb_phase();
        #1;
        chk("stall", {31'd0, stall}, {31'd0, ref_stall()});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready) && !ref_stall()});
    endtask

    task automatic edge_phase();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_ctrl", {24'd0, out_ctrl}, {24'd0, m_ctrl});
        chk("stall_count", {16'd0, stall_count}, {16'd0, m_cnt});
        if (m_valid) begin
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_imm", out_imm, m_imm);
            chk("out_pc", out_pc, m_pc);
        end
    endtask

    task automatic step();
        comb_phase();
        edge_phase();
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1;
        rs1 = 0; rs2 = 0; rd = 0; ctrl = 0;
        read_data1 = 0; read_data2 = 0; imm = 0; pc = 0;
        exmem_rd = 0; exmem_we = 0; exmem_result = 0;
        memwb_rd = 0; memwb_we = 0; memwb_result = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_a"}, out_a, 32'd0);
        chk({tag, "_b"}, out_b, 32'd0);
        chk({tag, "_imm"}, out_imm, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_ctrl"}, {24'd0, out_ctrl}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, stall_count}, 32'd0);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1;
        #2;
        chk_all_zero("reset");
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 0;

        // EX/MEM has priority over MEM/WB for the same register
        in_valid = 1; rs1 = 5; rd = 7; ctrl = 8'h01; read_data1 = 32'h33;
        imm = 32'h100; pc = 32'h1000;
        exmem_we = 1; exmem_rd = 5; exmem_result = 32'h11;
        memwb_we = 1; memwb_rd = 5; memwb_result = 32'h22;
        step();
`ifdef ID_EX_FWD_EN
        chk("fwd_exmem_prio", out_a, 32'h11);
        chk("fwd_capture", {31'd0, out_valid}, 32'd1);
`else
        chk("nofwd_raw_bubble", {31'd0, out_valid}, 32'd0);
        chk("nofwd_raw_count", {16'd0, stall_count}, 32'd1);
`endif

        // x0 is never forwarded
        idle();
        in_valid = 1; rs1 = 0; rd = 8; ctrl = 8'h01; read_data1 = 32'h44;
        exmem_we = 1; exmem_rd = 0; exmem_result = 32'hFF;
        step();
        chk("x0_zero", out_a, 32'd0);
        chk("x0_capture", {31'd0, out_valid}, 32'd1);

        // Clean restart so the stall counter starts from zero
        idle();
        rst = 1; #1;
        model_reset();
        chk("rst2_cnt", {16'd0, stall_count}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Load-use: held lw x3, next instruction reads x3 through rs2
        in_valid = 1; rd = 3; ctrl = 8'h03; pc = 32'h2000;
        step();
        rd = 4; rs2 = 3; ctrl = 8'h01; read_data2 = 32'h55; pc = 32'h2004;
        comb_phase();
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
        edge_phase();
        chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("lu_bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        comb_phase();
        chk("lu_stall_clear", {31'd0, stall}, 32'd0);
        edge_phase();
        chk("lu_capture_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_capture_rd", {27'd0, out_rd}, 32'd4);
        chk("lu_capture_b", out_b, 32'h55);
        chk("lu_count_hold", {16'd0, stall_count}, 32'd1);

        // Backpressure for three cycles: held instruction must not move
        out_ready = 0; rs1 = 1; rs2 = 0; rd = 9; ctrl = 8'h05; read_data2 = 32'h66;
        for (int i = 0; i < 3; i++) begin
            comb_phase();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            edge_phase();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_rd", {27'd0, out_rd}, 32'd4);
            chk("bp_b", out_b, 32'h55);
            chk("bp_ctrl", {24'd0, out_ctrl}, 32'h01);
            chk("bp_pc", out_pc, 32'h2004);
        end

        // Flush overrides everything
        flush = 1; in_valid = 1;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ctrl", {24'd0, out_ctrl}, 32'd0);

        // Reset in the middle of a stall
        idle();
        in_valid = 1; rd = 6; ctrl = 8'h03; imm = 32'h7; pc = 32'h3000;
        step();
        rs1 = 6; rd = 10; ctrl = 8'h01; out_ready = 0; pc = 32'h3004;
        step();
        step();
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        #1;
        rst = 1;
        #1;
        chk_all_zero("midstall_rst");
        model_reset();
        in_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        step();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

        // Random traffic against the reference
        for (int c = 0; c < 600; c++) begin
            in_valid     = ($urandom_range(0, 9) < 8);
            flush        = ($urandom_range(0, 19) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            rs1          = 5'($urandom_range(0, 7));
            rs2          = 5'($urandom_range(0, 7));
            rd           = 5'($urandom_range(0, 7));
            ctrl         = 8'($urandom);
            read_data1   = $urandom;
            read_data2   = $urandom;
            imm          = $urandom;
            pc           = $urandom;
            exmem_we     = $urandom_range(0, 1) == 1;
            exmem_rd     = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_we     = $urandom_range(0, 1) == 1;
            memwb_rd     = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
